team_select_fsm: RTL and testbench
==================================

TEAM_SELECT_FSM -- requirements
Module: team_select_fsm

Interface
REQ-001 The block SHALL have parameter COLS, default 4, meaning chooser grid columns (>=2).
REQ-002 The block SHALL have parameter ROWS, default 2, meaning chooser grid rows (>=2).
REQ-003 The block SHALL have parameter TEAM_SIZE, default 3, meaning slots to fill (1..COLS*ROWS).
REQ-004 The block SHALL have parameter ID_W, default $clog2(COLS*ROWS), meaning width of one grid index.
REQ-005 The block SHALL have parameter CNT_W, default $clog2(TEAM_SIZE+1), meaning slot-count width.
REQ-006 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-007 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port keycode, input, 8 bits: USB HID keycode, 0 = no key.
REQ-009 The block SHALL have port enable, input, 1 bit: leaves IDLE for SELECT.
REQ-010 The block SHALL have port clear, input, 1 bit: returns to IDLE and empties the team.
REQ-011 The block SHALL have port cur_choice, output, ID_W bits: equal to row*COLS + col.
REQ-012 The block SHALL have port my_team, output, TEAM_SIZE x ID_W bits: the chosen indices, slot 0 first.
REQ-013 The block SHALL have port num_chosen, output, CNT_W bits: count of filled slots.
REQ-014 The block SHALL have port done_select, output, 1 bit: high only in DONE.
REQ-015 The block SHALL have port reject, output, 1 bit: one-cycle pulse when a pick is refused.
REQ-016 The block SHALL have port state_o, output, 2 bits: IDLE=0, SELECT=1, CONFIRM=2, DONE=3.

Function
REQ-017 Key event: a key SHALL act only in the cycle where keycode != 0 and keycode != the value registered on the previous cycle; a held key acts once.
REQ-018 Keys SHALL be W=0x1A, A=0x04, S=0x16, D=0x07, ENTER=0x28, BACKSPACE=0x2A; any other code is ignored.
REQ-019 In SELECT only: W SHALL set row-1, wrapping 0->ROWS-1; S SHALL set row+1, wrapping ROWS-1->0; A SHALL set col-1, wrapping 0->COLS-1; D SHALL set col+1, wrapping COLS-1->0; cur_choice SHALL update the next cycle.
REQ-020 ENTER in SELECT with cur_choice not already in slots 0..num_chosen-1 SHALL write my_team[num_chosen]=cur_choice and increment num_chosen.
REQ-021 ENTER in SELECT on a duplicate index SHALL leave the team unchanged and pulse reject for exactly one cycle.
REQ-022 When an accepted ENTER makes num_chosen reach TEAM_SIZE, the FSM SHALL enter CONFIRM on that same edge.
REQ-023 BACKSPACE in SELECT with num_chosen>0, or in CONFIRM, SHALL decrement num_chosen and zero the vacated slot; in CONFIRM it SHALL also return to SELECT.
REQ-024 BACKSPACE in SELECT with num_chosen=0 SHALL be ignored, with no reject pulse.
REQ-025 ENTER in CONFIRM SHALL go to DONE; all other keys in CONFIRM SHALL be ignored.
REQ-026 In DONE, keys SHALL be ignored, and my_team, num_chosen and done_select SHALL hold until clear.
REQ-027 IDLE SHALL ignore keys; enable SHALL move IDLE->SELECT with the cursor at 0,0.
REQ-028 clear SHALL take priority over keys and enable in every state: next cycle state=IDLE, num_chosen=0, all slots 0, cursor 0,0, done_select=0.
REQ-029 num_chosen SHALL never exceed TEAM_SIZE or underflow below 0.

Reset
REQ-030 With Reset high at a posedge, the next outputs SHALL be state_o=IDLE, cur_choice=0, num_chosen=0, my_team all 0, done_select=0, reject=0, previous-keycode register 0.
REQ-031 Reset SHALL override clear, enable and keycode, including mid-selection or in DONE.

Verification
REQ-032 Reset; enable; keys D,D,D,D, each with an intervening 0 -> cur_choice 1,2,3,0 (column wraps).
REQ-033 In SELECT, hold D for 10 cycles -> cur_choice advances by exactly 1.
REQ-034 ENTER@0, then D, ENTER@1, then A, ENTER@0 -> reject one cycle; num_chosen=2; my_team[0]=0, my_team[1]=1.
REQ-035 Fill picks 0,5,7 -> state CONFIRM; BACKSPACE -> SELECT, num_chosen=2, slot2=0; ENTER on 7 then ENTER -> DONE, done_select=1, team {0,5,7}.
REQ-036 In DONE assert clear together with keycode ENTER -> IDLE, all outputs 0; repeat the test with Reset mid-SELECT and get the same outputs.
REQ-037 With COLS=3, ROWS=3, TEAM_SIZE=4: W from row 0 -> row 2, cur_choice=6; four distinct picks -> CONFIRM.

Source files
------------

// File: rtl/team_select_fsm.sv
// team_select_fsm
//   Keyboard-driven team chooser. A cursor moves over a COLS x ROWS grid
//   (W/A/S/D, with wrap-around). ENTER adds the cursor index to the team.
//   BACKSPACE removes the last pick. When TEAM_SIZE slots are full the FSM
//   waits in CONFIRM for a final ENTER (DONE) or a BACKSPACE (back to SELECT).
//
// Ports
//   Clk         : clock; all state changes on the rising edge
//   Reset       : synchronous, active-high reset
//   keycode     : USB HID keycode (0 = no key); only a new non-zero code acts
//   enable      : IDLE -> SELECT
//   clear       : back to IDLE with an empty team (beats keys and enable)
//   cur_choice  : cursor index, row*COLS + col
//   my_team     : chosen indices, slot 0 in my_team[0]
//   num_chosen  : number of filled slots
//   done_select : high while in DONE
//   reject      : one-cycle pulse when ENTER hits an index already chosen
//   state_o     : IDLE=0, SELECT=1, CONFIRM=2, DONE=3
module team_select_fsm #(
    parameter int COLS      = 4,
    parameter int ROWS      = 2,
    parameter int TEAM_SIZE = 3,
    parameter int ID_W      = $clog2(COLS*ROWS),
    parameter int CNT_W     = $clog2(TEAM_SIZE+1)
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [7:0]                        keycode,
    input  logic                              enable,
    input  logic                              clear,
    output logic [ID_W-1:0]                   cur_choice,
    output logic [TEAM_SIZE-1:0][ID_W-1:0]    my_team,
    output logic [CNT_W-1:0]                  num_chosen,
    output logic                              done_select,
    output logic                              reject,
    output logic [1:0]                        state_o
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CONFIRM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                           state_q, state_n;
    logic [RW-1:0]                    row_q, row_n;
    logic [CW-1:0]                    col_q, col_n;
    logic [TEAM_SIZE-1:0][ID_W-1:0]   team_q, team_n;
    logic [CNT_W-1:0]                 num_q, num_n;
    logic                             reject_q, reject_n;
    logic [7:0]                       prev_key_q;
    logic                             key_ev;
    logic                             dup;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            team_q     <= '0;
            num_q      <= '0;
            reject_q   <= 1'b0;
            prev_key_q <= '0;
        end else begin
            state_q    <= state_n;
            row_q      <= row_n;
            col_q      <= col_n;
            team_q     <= team_n;
            num_q      <= num_n;
            reject_q   <= reject_n;
            prev_key_q <= keycode;
        end
    end

    // A held key acts only on the cycle it first appears.
    assign key_ev = (keycode != 8'h00) && (keycode != prev_key_q);

    always_comb begin
        cur_choice = ID_W'(row_q) * ID_W'(COLS) + ID_W'(col_q);
    end

    // Only the filled slots take part in the duplicate check.
    always_comb begin
        dup = 1'b0;
        for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
            if ((CNT_W'(i) < num_q) && (team_q[i] == cur_choice))
                dup = 1'b1;
        end
    end

    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        col_n    = col_q;
        team_n   = team_q;
        num_n    = num_q;
        reject_n = 1'b0;

        if (clear) begin
            state_n = IDLE;
            row_n   = '0;
            col_n   = '0;
            team_n  = '0;
            num_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_n = SELECT;
                        row_n   = '0;
                        col_n   = '0;
                    end
                end
                SELECT: begin
                    if (key_ev) begin
                        case (keycode)
                            KEY_W: row_n = (row_q == '0) ? RW'(ROWS-1) : row_q - 1'b1;
                            KEY_S: row_n = (row_q == RW'(ROWS-1)) ? '0 : row_q + 1'b1;
                            KEY_A: col_n = (col_q == '0) ? CW'(COLS-1) : col_q - 1'b1;
                            KEY_D: col_n = (col_q == CW'(COLS-1)) ? '0 : col_q + 1'b1;
                            KEY_ENTER: begin
                                if (dup) begin
                                    reject_n = 1'b1;
                                end else if (num_q < CNT_W'(TEAM_SIZE)) begin
                                    for (int unsigned i = 0; i < TEAM_SIZE; i++)
                                        if (CNT_W'(i) == num_q)
                                            team_n[i] = cur_choice;
                                    num_n = num_q + 1'b1;
                                    if (num_q + 1'b1 == CNT_W'(TEAM_SIZE))
                                        state_n = CONFIRM;
                                end
                            end
                            KEY_BKSP: begin
                                if (num_q != '0) begin
                                    for (int unsigned i = 0; i < TEAM_SIZE; i++)
                                        if (CNT_W'(i) == num_q - 1'b1)
                                            team_n[i] = '0;
                                    num_n = num_q - 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                CONFIRM: begin
                    if (key_ev) begin
                        if (keycode == KEY_ENTER) begin
                            state_n = DONE;
                        end else if (keycode == KEY_BKSP) begin
                            for (int unsigned i = 0; i < TEAM_SIZE; i++)
                                if (CNT_W'(i) == num_q - 1'b1)
                                    team_n[i] = '0;
                            num_n   = num_q - 1'b1;
                            state_n = SELECT;
                        end
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign my_team     = team_q;
    assign num_chosen  = num_q;
    assign reject      = reject_q;
    assign done_select = (state_q == DONE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_team_select_fsm.sv
module tb_team_select_fsm;

    localparam logic [7:0] KW = 8'h1A, KA = 8'h04, KS = 8'h16, KD = 8'h07;
    localparam logic [7:0] KE = 8'h28, KB = 8'h2A;
    localparam logic [1:0] I = 2'd0, S = 2'd1, C = 2'd2, D = 2'd3;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Default-parameter DUT: 4 columns x 2 rows, team of 3
    logic             rst, en, clr;
    logic [7:0]       key;
    logic [2:0]       cur;
    logic [2:0][2:0]  team;
    logic [1:0]       num;
    logic             done, rej;
    logic [1:0]       st;

    team_select_fsm dut (
        .Clk(Clk), .Reset(rst), .keycode(key), .enable(en), .clear(clr),
        .cur_choice(cur), .my_team(team), .num_chosen(num),
        .done_select(done), .reject(rej), .state_o(st)
    );

    // 3 x 3 grid, team of 4
    logic             b_rst, b_en, b_clr;
    logic [7:0]       b_key;
    logic [3:0]       b_cur;
    logic [3:0][3:0]  b_team;
    logic [2:0]       b_num;
    logic             b_done, b_rej;
    logic [1:0]       b_st;

    team_select_fsm #(.COLS(3), .ROWS(3), .TEAM_SIZE(4)) dut_b (
        .Clk(Clk), .Reset(b_rst), .keycode(b_key), .enable(b_en), .clear(b_clr),
        .cur_choice(b_cur), .my_team(b_team), .num_chosen(b_num),
        .done_select(b_done), .reject(b_rej), .state_o(b_st)
    );

    typedef struct {
        logic       rst, en, clr;
        logic [7:0] key;
        logic [1:0] st;
        logic [2:0] cur;
        logic [1:0] num;
        logic       done, rej;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(logic r, logic e, logic c, logic [7:0] k,
                                logic [1:0] s, logic [2:0] cu, logic [1:0] n,
                                logic d, logic rj);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.key = k;
        v.st = s; v.cur = cu; v.num = n; v.done = d; v.rej = rj;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [1:0] es, input logic [2:0] ec,
                         input logic [1:0] en_, input logic ed, input logic er);
        chk({name, ".state"}, 32'(st), 32'(es));
        chk({name, ".cur"},   32'(cur), 32'(ec));
        chk({name, ".num"},   32'(num), 32'(en_));
        chk({name, ".done"},  32'(done), 32'(ed));
        chk({name, ".reject"}, 32'(rej), 32'(er));
    endtask

    task automatic chk_team(input string name, input logic [2:0] t0,
                            input logic [2:0] t1, input logic [2:0] t2);
        chk({name, ".slot0"}, 32'(team[0]), 32'(t0));
        chk({name, ".slot1"}, 32'(team[1]), 32'(t1));
        chk({name, ".slot2"}, 32'(team[2]), 32'(t2));
    endtask

    // Apply inputs for one clock and sample just after the edge.
    task automatic drive(input logic r, input logic e, input logic c, input logic [7:0] k);
        rst = r; en = e; clr = c; key = k;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_b(input logic r, input logic e, input logic c, input logic [7:0] k);
        b_rst = r; b_en = e; b_clr = c; b_key = k;
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        drive(1'b0, 1'b0, 1'b0, k);
    endtask

    task automatic press_b(input logic [7:0] k);
        drive_b(1'b0, 1'b0, 1'b0, k);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; key = 8'h00;
        b_rst = 1'b1; b_en = 1'b0; b_clr = 1'b0; b_key = 8'h00;

        // Reset with enable and a key present, then IDLE ignores keys
        add(1, 1, 0, KE, I, 0, 0, 0, 0);
        add(0, 0, 0, KD, I, 0, 0, 0, 0);
        add(0, 1, 0, 0,  S, 0, 0, 0, 0);
        // Column wrap: D x4 -> 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            add(0, 0, 0, KD, S, 3'(i % 4), 0, 0, 0);
            add(0, 0, 0, 0,  S, 3'(i % 4), 0, 0, 0);
        end
        // Held D acts once
        for (int i = 0; i < 10; i++) add(0, 0, 0, KD, S, 1, 0, 0, 0);
        add(0, 0, 0, 0, S, 1, 0, 0, 0);
        // Pick 0, pick 1, duplicate 0 -> reject for one cycle
        add(0, 0, 0, KA, S, 0, 0, 0, 0);  add(0, 0, 0, 0, S, 0, 0, 0, 0);
        add(0, 0, 0, KE, S, 0, 1, 0, 0);  add(0, 0, 0, 0, S, 0, 1, 0, 0);
        add(0, 0, 0, KD, S, 1, 1, 0, 0);  add(0, 0, 0, 0, S, 1, 1, 0, 0);
        add(0, 0, 0, KE, S, 1, 2, 0, 0);  add(0, 0, 0, 0, S, 1, 2, 0, 0);
        add(0, 0, 0, KA, S, 0, 2, 0, 0);  add(0, 0, 0, 0, S, 0, 2, 0, 0);
        add(0, 0, 0, KE, S, 0, 2, 0, 1);  add(0, 0, 0, 0, S, 0, 2, 0, 0);
        // Row wrap W: 0 -> 1 (cur 4); S: 1 -> 0; unknown key ignored
        add(0, 0, 0, KW, S, 4, 2, 0, 0);  add(0, 0, 0, 0, S, 4, 2, 0, 0);
        add(0, 0, 0, KS, S, 0, 2, 0, 0);  add(0, 0, 0, 0, S, 0, 2, 0, 0);
        add(0, 0, 0, 8'h55, S, 0, 2, 0, 0); add(0, 0, 0, 0, S, 0, 2, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].key);
            chk_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].cur, tbl[i].num,
                  tbl[i].done, tbl[i].rej);
        end
        chk_team("after_dup", 0, 1, 0);

        // Backspace down to empty; extra backspace is silent
        press(KB); chk_a("bs1", S, 0, 1, 0, 0); chk_team("bs1", 0, 0, 0); press(0);
        press(KB); chk_a("bs2", S, 0, 0, 0, 0); press(0);
        press(KB); chk_a("bs_empty", S, 0, 0, 0, 0); press(0);
        chk_a("bs_empty_next", S, 0, 0, 0, 0);

        // Pick 0,5,7 -> CONFIRM
        press(KE); press(0);
        press(KS); press(0);
        press(KD); chk_a("cur5", S, 5, 1, 0, 0); press(0);
        press(KE); press(0);
        press(KD); press(0);
        press(KD); press(0);
        press(KE); chk_a("full", C, 7, 3, 0, 0); chk_team("full", 0, 5, 7); press(0);
        press(KD); chk_a("confirm_ignore", C, 7, 3, 0, 0); press(0);
        press(KB); chk_a("confirm_bs", S, 7, 2, 0, 0); chk_team("confirm_bs", 0, 5, 0); press(0);
        press(KE); chk_a("refill", C, 7, 3, 0, 0); press(0);
        press(KE); chk_a("done", D, 7, 3, 1, 0); chk_team("done", 0, 5, 7); press(0);
        press(KB); chk_a("done_hold", D, 7, 3, 1, 0); chk_team("done_hold", 0, 5, 7); press(0);

        // clear beats ENTER and enable
        drive(1'b0, 1'b1, 1'b1, KE);
        chk_a("clear", I, 0, 0, 0, 0); chk_team("clear", 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-SELECT gives the same zeroed outputs
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        press(KS); press(0);
        press(KE); chk_a("pre_reset", S, 4, 1, 0, 0); press(0);
        drive(1'b1, 1'b1, 1'b1, KE);
        chk_a("reset_mid", I, 0, 0, 0, 0); chk_team("reset_mid", 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);

        // 3x3 grid, team of 4
        drive_b(1'b1, 1'b0, 1'b0, 8'h00);
        chk("b_reset.state", 32'(b_st), 32'(I));
        drive_b(1'b0, 1'b1, 1'b0, 8'h00);
        press_b(KW); chk("b_wrapW.cur", 32'(b_cur), 32'd6); press_b(0);
        press_b(KE); press_b(0);
        press_b(KD); chk("b_cur7", 32'(b_cur), 32'd7); press_b(0);
        press_b(KE); press_b(0);
        press_b(KD); press_b(0);
        press_b(KE); chk("b_num3", 32'(b_num), 32'd3); chk("b_st3", 32'(b_st), 32'(S)); press_b(0);
        press_b(KS); chk("b_wrapS.cur", 32'(b_cur), 32'd2); press_b(0);
        press_b(KE);
        chk("b_full.state", 32'(b_st), 32'(C));
        chk("b_full.num", 32'(b_num), 32'd4);
        chk("b_slot0", 32'(b_team[0]), 32'd6);
        chk("b_slot1", 32'(b_team[1]), 32'd7);
        chk("b_slot2", 32'(b_team[2]), 32'd8);
        chk("b_slot3", 32'(b_team[3]), 32'd2);
        press_b(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
